ls_stream_sel_cfg_loader: RTL and testbench

Double-buffered configuration loader that feeds the packed load/store stream-select vectors to the stream-select unpacking stage in the execute path. Software writes 32-bit words into shadow registers through a valid/ready write port. A commit request then copies all shadow words into the active registers in one cycle. The copy happens only once the load/store streams report idle, so a crossbar select never changes while a stream is in flight.

---
 rtl/ls_stream_sel_cfg_loader.sv | 142 ++++++++++++++
 tb/tb_ls_stream_sel_cfg_loader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ls_stream_sel_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : ls_stream_sel_cfg_loader
// Purpose  : Double-buffered loader for the packed load/store stream-select
//            vectors. Software fills shadow words through a valid/ready write
//            port. A commit copies every shadow word into the active
//            registers in one cycle, once the load/store streams are idle.
//            This keeps a crossbar select from changing while a stream is in
//            flight.
// Ports    : clk_i, rst_i             - clock, synchronous active-high reset
//            wr_valid_i/wr_ready_o    - shadow write handshake
//            wr_addr_i, wr_data_i     - word address and 32-bit data
//            commit_i                 - request to apply shadow to active
//            streams_idle_i           - no load/store stream in flight
//            reg_cfg_l_stream_sel_o   - active load-select vector
//            reg_cfg_s_stream_sel_o   - active store-select vector
//            cfg_pending_o            - commit requested, not yet applied
//            cfg_applied_o            - pulse: new active values visible
//            wr_err_o                 - pulse: accepted write was unmapped
//            cfg_gen_o                - applied-commit count (wrapping)
// Revision : 1.0 - initial release
// ============================================================================
module ls_stream_sel_cfg_loader #(
  parameter int N_L_REGS = 2,
  parameter int N_S_REGS = 2,
  parameter int ADDR_W   = 4,
  parameter int GEN_W    = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [ADDR_W-1:0]     wr_addr_i,
  input  logic [31:0]           wr_data_i,
  input  logic                  commit_i,
  input  logic                  streams_idle_i,
  output logic [N_L_REGS*32-1:0] reg_cfg_l_stream_sel_o,
  output logic [N_S_REGS*32-1:0] reg_cfg_s_stream_sel_o,
  output logic                  cfg_pending_o,
  output logic                  cfg_applied_o,
  output logic                  wr_err_o,
  output logic [GEN_W-1:0]      cfg_gen_o
);

  localparam logic [ADDR_W:0] N_MAPPED = (ADDR_W+1)'(N_L_REGS + N_S_REGS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PEND  = 2'd1,
    S_APPLY = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [N_L_REGS*32-1:0] shadow_l;
  logic [N_S_REGS*32-1:0] shadow_s;
  logic [N_L_REGS*32-1:0] active_l;
  logic [N_S_REGS*32-1:0] active_s;
  logic [GEN_W-1:0]       gen;
  logic                   applied;
  logic                   err;

  logic wr_fire;
  logic addr_unmapped;

  // Shadow is only writable in IDLE, which freezes it for the whole commit.
  assign wr_fire       = wr_valid_i && (state == S_IDLE);
  assign addr_unmapped = ({1'b0, wr_addr_i} >= N_MAPPED);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (commit_i) state_nxt = S_PEND;
      S_PEND:  if (streams_idle_i) state_nxt = S_APPLY;
      S_APPLY: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Shadow / active registers, generation counter, status pulses
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_l <= '0;
      shadow_s <= '0;
      active_l <= '0;
      active_s <= '0;
      gen      <= '0;
      applied  <= 1'b0;
      err      <= 1'b0;
    end else begin
      // A write in the same cycle as commit_i still lands here, so the
      // commit that follows includes it.
      for (int w = 0; w < N_L_REGS; w++) begin
        if (wr_fire && (wr_addr_i == ADDR_W'(w))) begin
          shadow_l[32*w +: 32] <= wr_data_i;
        end
      end
      for (int w = 0; w < N_S_REGS; w++) begin
        if (wr_fire && (wr_addr_i == ADDR_W'(N_L_REGS + w))) begin
          shadow_s[32*w +: 32] <= wr_data_i;
        end
      end

      err     <= wr_fire && addr_unmapped;
      applied <= (state == S_APPLY);

      if (state == S_APPLY) begin
        active_l <= shadow_l;
        active_s <= shadow_s;
        gen      <= gen + GEN_W'(1);
      end
    end
  end

  // All outputs come straight from registers: no input-to-output path.
  assign wr_ready_o             = (state == S_IDLE);
  assign cfg_pending_o          = (state == S_PEND) || (state == S_APPLY);
  assign cfg_applied_o          = applied;
  assign wr_err_o               = err;
  assign cfg_gen_o              = gen;
  assign reg_cfg_l_stream_sel_o = active_l;
  assign reg_cfg_s_stream_sel_o = active_s;

endmodule
`default_nettype wire

// File: tb/tb_ls_stream_sel_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ls_stream_sel_cfg_loader
// Purpose  : Self-checking bench for ls_stream_sel_cfg_loader. A
//            transaction-level reference model tracks the shadow and active
//            words and the commit count. Directed scenarios are followed by
//            randomized writes and commits.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ls_stream_sel_cfg_loader;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        wr_valid_i;
  logic        wr_ready_o;
  logic [3:0]  wr_addr_i;
  logic [31:0] wr_data_i;
  logic        commit_i;
  logic        streams_idle_i;
  logic [63:0] reg_cfg_l_stream_sel_o;
  logic [63:0] reg_cfg_s_stream_sel_o;
  logic        cfg_pending_o;
  logic        cfg_applied_o;
  logic        wr_err_o;
  logic [7:0]  cfg_gen_o;

  ls_stream_sel_cfg_loader #(
    .N_L_REGS(2), .N_S_REGS(2), .ADDR_W(4), .GEN_W(8)
  ) dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .wr_valid_i             (wr_valid_i),
    .wr_ready_o             (wr_ready_o),
    .wr_addr_i              (wr_addr_i),
    .wr_data_i              (wr_data_i),
    .commit_i               (commit_i),
    .streams_idle_i         (streams_idle_i),
    .reg_cfg_l_stream_sel_o (reg_cfg_l_stream_sel_o),
    .reg_cfg_s_stream_sel_o (reg_cfg_s_stream_sel_o),
    .cfg_pending_o          (cfg_pending_o),
    .cfg_applied_o          (cfg_applied_o),
    .wr_err_o               (wr_err_o),
    .cfg_gen_o              (cfg_gen_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: word index 0..1 = load words, 2..3 = store words.
  logic [31:0] m_sh  [4];
  logic [31:0] m_act [4];
  logic [7:0]  m_gen;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_applied_pulses = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_sh[i]  = '0;
      m_act[i] = '0;
    end
    m_gen = '0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_active(input string tag);
    check({tag, "_l"},   reg_cfg_l_stream_sel_o, {m_act[1], m_act[0]});
    check({tag, "_s"},   reg_cfg_s_stream_sel_o, {m_act[3], m_act[2]});
    check({tag, "_gen"}, {56'd0, cfg_gen_o},     {56'd0, m_gen});
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d);
    check("wr_ready_idle", {63'd0, wr_ready_o}, 64'd1);
    wr_valid_i = 1'b1;
    wr_addr_i  = a;
    wr_data_i  = d;
    step();
    wr_valid_i = 1'b0;
    if (a < 4) m_sh[a] = d;
    check("wr_err", {63'd0, wr_err_o}, {63'd0, (a >= 4'd4)});
    check_active("wr_act");
    step();
    check("wr_err_clear", {63'd0, wr_err_o}, 64'd0);
  endtask

  // Commit with 'delay' low samples of streams_idle_i while pending, and an
  // optional write presented in the same cycle as commit_i.
  task automatic do_commit(input int delay, input bit wr, input logic [3:0] a, input logic [31:0] d);
    commit_i       = 1'b1;
    streams_idle_i = (delay == 0);
    wr_valid_i     = wr;
    wr_addr_i      = a;
    wr_data_i      = d;
    step();
    commit_i   = 1'b0;
    wr_valid_i = 1'b0;
    if (wr && a < 4) m_sh[a] = d;
    check("c_wr_err",    {63'd0, wr_err_o},      {63'd0, (wr && a >= 4'd4)});
    check("c_pend",      {63'd0, cfg_pending_o}, 64'd1);
    check("c_ready",     {63'd0, wr_ready_o},    64'd0);
    check("c_applied",   {63'd0, cfg_applied_o}, 64'd0);
    check_active("c_act_pend");
    for (int i = 0; i < delay; i++) begin
      streams_idle_i = 1'b0;
      commit_i       = 1'($urandom_range(0, 1));
      wr_valid_i     = 1'b1;
      wr_addr_i      = 4'($urandom_range(0, 15));
      wr_data_i      = $urandom;
      step();
      check("w_pend",  {63'd0, cfg_pending_o}, 64'd1);
      check("w_ready", {63'd0, wr_ready_o},    64'd0);
      check("w_err",   {63'd0, wr_err_o},      64'd0);
      check_active("w_act");
    end
    commit_i       = 1'b0;
    wr_valid_i     = 1'b0;
    streams_idle_i = 1'b1;
    step();
    check("a_pend",    {63'd0, cfg_pending_o}, 64'd1);
    check("a_ready",   {63'd0, wr_ready_o},    64'd0);
    check("a_applied", {63'd0, cfg_applied_o}, 64'd0);
    check_active("a_act");
    streams_idle_i = 1'($urandom_range(0, 1));
    step();
    for (int i = 0; i < 4; i++) m_act[i] = m_sh[i];
    m_gen = m_gen + 8'd1;
    if (cfg_applied_o) n_applied_pulses++;
    check("d_applied", {63'd0, cfg_applied_o}, 64'd1);
    check("d_pend",    {63'd0, cfg_pending_o}, 64'd0);
    check("d_ready",   {63'd0, wr_ready_o},    64'd1);
    check_active("d_act");
    step();
    check("d_applied_clear", {63'd0, cfg_applied_o}, 64'd0);
  endtask

  initial begin
    rst_i          = 1'b1;
    wr_valid_i     = 1'b0;
    wr_addr_i      = '0;
    wr_data_i      = '0;
    commit_i       = 1'b0;
    streams_idle_i = 1'b1;
    model_reset();
    step();
    step();
    rst_i = 1'b0;

    // Reset state
    check("rst_ready",   {63'd0, wr_ready_o},    64'd1);
    check("rst_pend",    {63'd0, cfg_pending_o}, 64'd0);
    check("rst_applied", {63'd0, cfg_applied_o}, 64'd0);
    check("rst_err",     {63'd0, wr_err_o},      64'd0);
    check_active("rst_act");

    // Basic write + commit
    do_write(4'd0, 32'hDEADBEEF);
    do_write(4'd3, 32'h12345678);
    do_commit(0, 1'b0, 4'd0, 32'd0);
    check("basic_l0", {32'd0, reg_cfg_l_stream_sel_o[31:0]},  64'hDEADBEEF);
    check("basic_s1", {32'd0, reg_cfg_s_stream_sel_o[63:32]}, 64'h12345678);

    // Commit held off by busy streams
    do_write(4'd2, 32'h0BADF00D);
    do_commit(5, 1'b0, 4'd0, 32'd0);

    // Write and commit in the same cycle
    do_commit(0, 1'b1, 4'd1, 32'hA5A5A5A5);
    check("same_cyc_l1", {32'd0, reg_cfg_l_stream_sel_o[63:32]}, 64'hA5A5A5A5);

    // Unmapped write, then commit leaves everything as before
    do_write(4'd4, 32'hCAFEF00D);
    do_commit(0, 1'b0, 4'd0, 32'd0);

    // Generation counter wrap
    for (int i = 0; i < 256; i++) begin
      do_commit(0, 1'b0, 4'd0, 32'd0);
    end
    check("wrap_pulses", 64'(n_applied_pulses), 64'd260);

    // Reset during PEND aborts the commit
    do_write(4'd0, 32'hFFFFFFFF);
    commit_i       = 1'b1;
    streams_idle_i = 1'b0;
    step();
    commit_i = 1'b0;
    check("abort_pend", {63'd0, cfg_pending_o}, 64'd1);
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    model_reset();
    streams_idle_i = 1'b1;
    check("abort_ready",   {63'd0, wr_ready_o},    64'd1);
    check("abort_pend0",   {63'd0, cfg_pending_o}, 64'd0);
    check("abort_applied", {63'd0, cfg_applied_o}, 64'd0);
    check_active("abort_act");
    step();
    check("abort_no_pulse", {63'd0, cfg_applied_o}, 64'd0);
    do_commit(0, 1'b0, 4'd0, 32'd0);

    // Randomized writes and commits
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        do_write(4'($urandom_range(0, 15)), $urandom);
      end else begin
        do_commit(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 5)), $urandom);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
